// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one SRAM controller port between the MEM stage (port 0) and the loader/DMA (port 1).
// Grant in IDLE, hold the latched request through BUSY until mem_ready, then a one-cycle DONE with per-port ready.
module sram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_rd,
  input  logic              p0_wr,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_ready,
  input  logic              p1_rd,
  input  logic              p1_wr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_ready,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_q, state_d;
  logic                last_q, last_d;
  logic                owner_q, owner_d;
  logic                op_wr_q, op_wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [1:0]          grant_q, grant_d;
  logic [DATA_W-1:0]   p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0]   p1_rdata_q, p1_rdata_d;
  logic                done0_q, done0_d;
  logic                done1_q, done1_d;
  logic                req0, req1;

  assign req0 = p0_rd | p0_wr;
  assign req1 = p1_rd | p1_wr;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    op_wr_d    = op_wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    grant_d    = grant_q;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          // On a tie the port that did not win last time goes next.
          owner_d = (req0 & req1) ? ~last_q : req1;
          op_wr_d = owner_d ? p1_wr : p0_wr;
          addr_d  = owner_d ? p1_addr : p0_addr;
          wdata_d = owner_d ? p1_wdata : p0_wdata;
          last_d  = owner_d;
          grant_d = owner_d ? 2'b10 : 2'b01;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          if (!op_wr_q) begin
            if (owner_q) p1_rdata_d = mem_rdata;
            else         p0_rdata_d = mem_rdata;
          end
          done0_d = ~owner_q;
          done1_d = owner_q;
          grant_d = 2'b00;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      op_wr_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      grant_q    <= 2'b00;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      op_wr_q    <= op_wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      grant_q    <= grant_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
    end
  end

  // Controller strobes come only from latched state, so requester churn cannot leak through.
  assign mem_rd    = (state_q == BUSY) & ~op_wr_q;
  assign mem_wr    = (state_q == BUSY) & op_wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign grant     = grant_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign p0_ready  = ~req0 | done0_q;
  assign p1_ready  = ~req1 | done1_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Random two-port traffic against a transaction-level model of the arbiter and a wait-state SRAM.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_rd, p0_wr, p1_rd, p1_wr;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [31:0] p0_rdata, p1_rdata;
  logic        p0_ready, p1_ready;
  logic        mem_rd, mem_wr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  grant;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .p0_rd(p0_rd), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rdata(p0_rdata), .p0_ready(p0_ready),
    .p1_rd(p1_rd), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(p1_rdata), .p1_ready(p1_ready),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .grant(grant)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // SRAM model and its reference image
  logic [31:0] mem_arr [16];
  logic [31:0] ref_mem [16];
  int          mem_cnt, mem_wait;

  // Requester drivers
  logic        rq_rd [2];
  logic        rq_wr [2];
  logic [31:0] rq_addr [2];
  logic [31:0] rq_wdata [2];
  bit          done_seen [2];

  // Transaction-level expectation: one active transaction with start cycle and wait count
  bit          m_act;
  int          m_start, m_w, m_owner, m_free;
  bit          m_wr, m_last;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rdata [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic new_op(input int p);
    int r;
    r = $urandom_range(1, 3);
    rq_rd[p]    = (r & 1) != 0;
    rq_wr[p]    = (r & 2) != 0;
    rq_addr[p]  = $urandom;
    rq_wdata[p] = $urandom;
  endtask

  task automatic apply_inputs();
    p0_rd = rq_rd[0]; p0_wr = rq_wr[0]; p0_addr = rq_addr[0]; p0_wdata = rq_wdata[0];
    p1_rd = rq_rd[1]; p1_wr = rq_wr[1]; p1_addr = rq_addr[1]; p1_wdata = rq_wdata[1];
  endtask

  task automatic drive();
    if (mem_rd | mem_wr) begin
      mem_cnt++;
      mem_ready = (mem_cnt == mem_wait);
    end else begin
      mem_cnt   = 0;
      mem_ready = 1'($urandom_range(0, 1));
    end
    mem_rdata = mem_arr[mem_addr[5:2]];
    for (int p = 0; p < 2; p++) begin
      if ((rq_rd[p] | rq_wr[p]) && done_seen[p]) begin
        rq_rd[p] = 1'b0; rq_wr[p] = 1'b0; done_seen[p] = 1'b0;
        if ($urandom_range(0, 1) == 1) new_op(p);
      end else if (!(rq_rd[p] | rq_wr[p])) begin
        if ($urandom_range(0, 3) == 0) new_op(p);
      end else if (m_act && m_owner == p && cyc > m_start && cyc <= m_start + m_w + 1
                   && $urandom_range(0, 1) == 1) begin
        rq_addr[p]  = $urandom;
        rq_wdata[p] = $urandom;
      end
    end
    apply_inputs();
  endtask

  task automatic observe();
    logic [1:0] req;
    bit done_cyc, busy;
    logic [1:0] exp_grant;
    req = {p1_rd | p1_wr, p0_rd | p0_wr};
    if (rst) begin
      m_act = 1'b0; m_last = 1'b1; m_free = cyc + 1;
      m_rdata[0] = '0; m_rdata[1] = '0;
      done_seen[0] = 1'b0; done_seen[1] = 1'b0;
      check_eq("rst_grant", 32'(grant), 32'd0);
      check_eq("rst_mem_rd", 32'(mem_rd), 32'd0);
      check_eq("rst_mem_wr", 32'(mem_wr), 32'd0);
      check_eq("rst_mem_addr", mem_addr, 32'd0);
      check_eq("rst_mem_wdata", mem_wdata, 32'd0);
      check_eq("rst_p0_rdata", p0_rdata, 32'd0);
      check_eq("rst_p1_rdata", p1_rdata, 32'd0);
      check_eq("rst_p0_ready", 32'(p0_ready), 32'(!req[0]));
      check_eq("rst_p1_ready", 32'(p1_ready), 32'(!req[1]));
      return;
    end
    if (mem_ready && mem_wr) mem_arr[mem_addr[5:2]] = mem_wdata;

    done_cyc = m_act && (cyc == m_start + m_w + 1);
    busy     = m_act && (cyc > m_start) && (cyc <= m_start + m_w);
    if (done_cyc) begin
      if (m_wr) ref_mem[m_addr[5:2]] = m_wdata;
      else      m_rdata[m_owner]     = ref_mem[m_addr[5:2]];
    end
    exp_grant = busy ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
    check_eq("grant", 32'(grant), 32'(exp_grant));
    check_eq("mem_rd", 32'(mem_rd), 32'(busy && !m_wr));
    check_eq("mem_wr", 32'(mem_wr), 32'(busy && m_wr));
    if (busy) begin
      check_eq("mem_addr", mem_addr, m_addr);
      check_eq("mem_wdata", mem_wdata, m_wdata);
    end
    check_eq("p0_rdata", p0_rdata, m_rdata[0]);
    check_eq("p1_rdata", p1_rdata, m_rdata[1]);
    check_eq("p0_ready", 32'(p0_ready), 32'(!req[0] || (done_cyc && m_owner == 0)));
    check_eq("p1_ready", 32'(p1_ready), 32'(!req[1] || (done_cyc && m_owner == 1)));
    done_seen[0] = req[0] && p0_ready;
    done_seen[1] = req[1] && p1_ready;

    if (done_cyc) begin
      m_act  = 1'b0;
      m_free = cyc + 1;
    end
    if (!m_act && cyc >= m_free && req != 2'b00) begin
      m_owner  = (req == 2'b11) ? (m_last ? 0 : 1) : (req[1] ? 1 : 0);
      m_wr     = rq_wr[m_owner];
      m_addr   = rq_addr[m_owner];
      m_wdata  = rq_wdata[m_owner];
      m_last   = (m_owner == 1);
      m_start  = cyc;
      m_w      = $urandom_range(1, 5);
      mem_wait = m_w;
      m_act    = 1'b1;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_arr[i] = $urandom;
      ref_mem[i] = mem_arr[i];
    end
    for (int p = 0; p < 2; p++) begin
      rq_rd[p] = 1'b0; rq_wr[p] = 1'b0; rq_addr[p] = '0; rq_wdata[p] = '0;
      done_seen[p] = 1'b0; m_rdata[p] = '0;
    end
    apply_inputs();
    rst = 1'b1; mem_ready = 1'b0; mem_rdata = '0;
    mem_cnt = 0; mem_wait = 1;
    m_act = 1'b0; m_last = 1'b1; m_free = 0; m_start = 0; m_w = 1; m_owner = 0;
    m_wr = 1'b0; m_addr = '0; m_wdata = '0;

    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      drive();
      // Asynchronous reset lands mid-cycle, often in the middle of a transaction.
      if (i < 3) rst = 1'b1;
      else if (rst) rst = 1'b0;
      else if ($urandom_range(0, 299) == 0) rst = 1'b1;
      @(negedge clk);
      observe();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
